pipeline_ctrl: RTL and testbench
================================

Name: pipeline_ctrl

Overview:
- Central stall/flush sequencer for one core's 5-stage pipeline.
- Drives en/flush of the PC and IF_ID, ID_EX, EX_MEM, MEM_WB latches, plus the dhit pulse forwarded into the MEM_WB latch.
- Arbitrates between halt, dcache wait, control-flow redirect, load-use hazard and icache miss using a small FSM; one instance per core.

Parameters:
- CNT_W, 32, width of optional performance counters.
- REG_W, 5, register index width (matches regbits_t).

Ports:
- CLK  in  1  core clock
- nRST  in  1  asynchronous active-low reset
- ihit  in  1  icache hit for current fetch
- dhit  in  1  dcache completes EX_MEM access this cycle
- exmem_dREN  in  1  load in EX_MEM
- exmem_dWEN  in  1  store in EX_MEM
- redirect  in  1  branch taken or jump resolved in EX_MEM
- idex_dREN  in  1  load in ID_EX
- idex_rd  in  REG_W  destination of ID_EX
- ifid_rs1, ifid_rs2  in  REG_W  sources decoded in IF_ID
- memwb_halt  in  1  halt_o of MEM_WB latch
- pc_en  out  1  PC update enable
- pc_redirect  out  1  PC mux selects redirect target
- ifid_en, idex_en, exmem_en, memwb_en  out  1 each  latch enables
- ifid_flush, idex_flush, exmem_flush, memwb_flush  out  1 each  latch flushes (bubble insert)
- memwb_dhit  out  1  dhit qualified for MEM_WB
- dREN_o, dWEN_o  out  1 each  gated dcache request
- halted  out  1  sticky core-halted flag
- state_o  out  2  current FSM state (debug)

Behaviour:
- Reset (async, nRST=0): state=RUN, halted=0. All outputs combinational from state and inputs. With no inputs asserted: all en=1, all flush=0.
- States: RUN=0, DWAIT=1, REDIR=2, HALT=3. State register only; control latency 0 cycles.
- Priority, highest first: HALT/memwb_halt > dmem stall > redirect > load-use > imiss.
- memwb_halt=1 in any state: next=HALT.
  - Same cycle: memwb_en=1 so halt retires; all other en=0, all other flush=0.
- HALT: all en=0, dREN_o=dWEN_o=0, halted=1. Exit only via reset.
- Dmem stall, mem = exmem_dREN|exmem_dWEN:
  - RUN, mem=1, dhit=0: next=DWAIT. pc/ifid/idex/exmem en=0; memwb_flush=1 (bubble into WB).
  - DWAIT: same outputs until dhit=1. On dhit: all latches enabled, memwb_dhit=1, next=RUN (or REDIR if redirect=1).
  - RUN, mem=1, dhit=1: one-cycle completion, no DWAIT entry.
- dREN_o/dWEN_o = exmem_dREN/dWEN except in HALT. They also drop to 0 in the cycle after dhit if EX_MEM did not advance (cannot happen under this priority; assertion only).
- Redirect (no dmem stall): pc_en=1, pc_redirect=1, ifid_flush=1, idex_flush=1, exmem_flush=1; next=REDIR.
- REDIR, one cycle: ifid_flush=1 forced, squashing the in-flight stale fetch. Next=RUN, unless a new event takes precedence.
- Load-use: idex_dREN=1, idex_rd!=0, idex_rd∈{ifid_rs1, ifid_rs2}.
  - pc_en=0, ifid_en=0, idex_flush=1; EX_MEM/MEM_WB advance.
- Imiss (ihit=0, no higher event): pc_en=0, ifid_flush=1; downstream advance.
- Simultaneous cases:
  - Redirect and load-use: redirect wins; the flushed IF_ID makes the hazard moot.
  - Redirect during DWAIT: held until dhit, then applied.
- Reset mid-DWAIT: FSM returns to RUN immediately; outstanding request abandoned (cache is reset by the same nRST).

Optional Feature:
- Macro PIPE_CTRL_PERF_EN.
- Defined: adds ports stall_cnt, flush_cnt, dwait_cnt (out, CNT_W).
  - stall_cnt: cycles with pc_en=0 and state!=HALT.
  - flush_cnt: redirect events.
  - dwait_cnt: cycles in DWAIT.
  - Async reset to 0; saturate at all-ones; frozen in HALT.
- Undefined: ports and logic absent; behaviour otherwise identical.

Decomposition:
- In cpu_types_pkg:
  - typedef enum logic [1:0] pctrl_state_t {RUN, DWAIT, REDIR, HALT}.
  - regbits_t is reused for REG_W fields.
- One sub-module, hazard_detect: pure combinational load-use compare, instantiated once.
- Counters stay inline.

Test Plan:
- Reset, then ihit=1, no events -> all en=1, flush=0, state_o=0, halted=0.
- exmem_dREN=1, dhit=0 for 3 cycles, then dhit=1:
  - state_o=1 for 3 cycles; pc/ifid/idex/exmem en=0 and memwb_flush=1 for 3 cycles.
  - dhit cycle: memwb_dhit=1, all en=1; state_o=0 next cycle.
- idex_dREN=1, idex_rd=5, ifid_rs2=5 -> pc_en=0, ifid_en=0, idex_flush=1, exmem_en=1.
  - Repeat with idex_rd=0 -> no stall.
- redirect=1 for 1 cycle -> pc_redirect=1, ifid/idex/exmem_flush=1.
  - Next cycle state_o=2 with ifid_flush=1; then state_o=0.
- memwb_halt=1 together with exmem_dWEN=1, dhit=0 -> halt wins; state_o=3, halted=1 sticky, dWEN_o=0.
  - nRST pulse mid-HALT -> state_o=0, halted=0 asynchronously.
- With PIPE_CTRL_PERF_EN, run the 3-cycle DWAIT scenario -> dwait_cnt=3, stall_cnt>=3.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared core types used by the pipeline controller.
//
// Contents:
//   REGBITS_W     - register index width
//   regbits_t     - register index type
//   pctrl_state_t - pipeline controller FSM states
//                   RUN=0, DWAIT=1, REDIR=2, HALT=3
package cpu_types_pkg;

  localparam int REGBITS_W = 5;

  typedef logic [REGBITS_W-1:0] regbits_t;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DWAIT = 2'd1,
    REDIR = 2'd2,
    HALT  = 2'd3
  } pctrl_state_t;

endpackage

// File: rtl/pipeline_ctrl_hazard_detect.sv
// hazard_detect: purely combinational load-use hazard compare.
//
// A load sitting in ID_EX whose destination is read by the instruction in
// IF_ID cannot be forwarded in time, so the front end must hold for a cycle.
// Register 0 is hardwired to zero and never creates a hazard.
//
// Ports:
//   i_idex_dREN  in   load in ID_EX
//   i_idex_rd    in   destination register of ID_EX
//   i_ifid_rs1   in   first source register decoded in IF_ID
//   i_ifid_rs2   in   second source register decoded in IF_ID
//   o_load_use   out  load-use hazard present
module hazard_detect
  import cpu_types_pkg::*;
(
  input  logic     i_idex_dREN,
  input  regbits_t i_idex_rd,
  input  regbits_t i_ifid_rs1,
  input  regbits_t i_ifid_rs2,
  output logic     o_load_use
);

  assign o_load_use = i_idex_dREN && (i_idex_rd != '0) &&
                      ((i_idex_rd == i_ifid_rs1) || (i_idex_rd == i_ifid_rs2));

endmodule

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: stall/flush sequencer for one core's 5-stage pipeline.
//
// Arbitrates, highest priority first: halt > dcache wait > control-flow
// redirect > load-use hazard > icache miss. Only the FSM state is registered;
// every control output is combinational from state and inputs.
//
// Parameters:
//   CNT_W  width of the optional performance counters
//   REG_W  register index width (must match regbits_t)
//
// Ports:
//   CLK, nRST                    clock, asynchronous active-low reset
//   ihit, dhit                   icache hit / dcache access complete
//   exmem_dREN, exmem_dWEN       load / store in EX_MEM
//   redirect                     branch taken or jump resolved in EX_MEM
//   idex_dREN, idex_rd           load and its destination in ID_EX
//   ifid_rs1, ifid_rs2           sources decoded in IF_ID
//   memwb_halt                   halt reaching MEM_WB
//   pc_en, pc_redirect           PC update enable / redirect target select
//   *_en, *_flush                latch enables and bubble inserts
//   memwb_dhit                   dhit qualified for MEM_WB
//   dREN_o, dWEN_o               gated dcache request
//   halted                       sticky core-halted flag
//   state_o                      current FSM state (debug)
//
// Optional feature, macro PIPE_CTRL_PERF_EN: adds saturating counters
//   stall_cnt (cycles with PC held outside HALT), flush_cnt (redirects
//   applied) and dwait_cnt (cycles in DWAIT). All freeze in HALT.
module pipeline_ctrl
  import cpu_types_pkg::*;
#(
  parameter int CNT_W = 32,
  parameter int REG_W = 5
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             ihit,
  input  logic             dhit,
  input  logic             exmem_dREN,
  input  logic             exmem_dWEN,
  input  logic             redirect,
  input  logic             idex_dREN,
  input  logic [REG_W-1:0] idex_rd,
  input  logic [REG_W-1:0] ifid_rs1,
  input  logic [REG_W-1:0] ifid_rs2,
  input  logic             memwb_halt,
  output logic             pc_en,
  output logic             pc_redirect,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exmem_en,
  output logic             memwb_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exmem_flush,
  output logic             memwb_flush,
  output logic             memwb_dhit,
  output logic             dREN_o,
  output logic             dWEN_o,
  output logic             halted,
  output logic [1:0]       state_o
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [CNT_W-1:0] dwait_cnt
`endif
);

  // Elaboration-time parameter sanity.
  if (REG_W != REGBITS_W) begin : g_reg_w_check
    $error("REG_W must match regbits_t width");
  end
  if (CNT_W < 1) begin : g_cnt_w_check
    $error("CNT_W must be positive");
  end

  pctrl_state_t r_state;
  pctrl_state_t w_next;
  logic         w_mem;
  logic         w_stall;
  logic         w_load_use;

  hazard_detect u_hazard_detect (
    .i_idex_dREN (idex_dREN),
    .i_idex_rd   (idex_rd),
    .i_ifid_rs1  (ifid_rs1),
    .i_ifid_rs2  (ifid_rs2),
    .o_load_use  (w_load_use)
  );

  assign w_mem   = exmem_dREN | exmem_dWEN;
  // DWAIT holds until dhit regardless of the (frozen) EX_MEM request.
  assign w_stall = !dhit && ((r_state == DWAIT) || w_mem);
  assign halted  = (r_state == HALT);
  assign state_o = r_state;

  // Control decode and next-state selection in priority order. A completing
  // dcache access falls through to the lower-priority events, which is how a
  // redirect held during DWAIT gets applied on the dhit cycle.
  always_comb begin
    w_next      = r_state;
    pc_en       = 1'b1;
    pc_redirect = 1'b0;
    ifid_en     = 1'b1;
    idex_en     = 1'b1;
    exmem_en    = 1'b1;
    memwb_en    = 1'b1;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    memwb_flush = 1'b0;
    memwb_dhit  = 1'b0;
    dREN_o      = exmem_dREN;
    dWEN_o      = exmem_dWEN;

    if (r_state == HALT) begin
      pc_en    = 1'b0;
      ifid_en  = 1'b0;
      idex_en  = 1'b0;
      exmem_en = 1'b0;
      memwb_en = 1'b0;
      dREN_o   = 1'b0;
      dWEN_o   = 1'b0;
    end else if (memwb_halt) begin
      // Only MEM_WB advances so the halt retires; everything else freezes.
      pc_en    = 1'b0;
      ifid_en  = 1'b0;
      idex_en  = 1'b0;
      exmem_en = 1'b0;
      w_next   = HALT;
    end else if (w_stall) begin
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      idex_en     = 1'b0;
      exmem_en    = 1'b0;
      memwb_flush = 1'b1;
      w_next      = DWAIT;
    end else begin
      memwb_dhit = dhit && (w_mem || (r_state == DWAIT));
      w_next     = RUN;
      if (redirect) begin
        pc_redirect = 1'b1;
        ifid_flush  = 1'b1;
        idex_flush  = 1'b1;
        exmem_flush = 1'b1;
        w_next      = REDIR;
      end else if (w_load_use) begin
        pc_en      = 1'b0;
        ifid_en    = 1'b0;
        idex_flush = 1'b1;
      end else if (!ihit) begin
        pc_en      = 1'b0;
        ifid_flush = 1'b1;
      end
      // The fetch in flight during the redirect came from the old path.
      if (r_state == REDIR) begin
        ifid_flush = 1'b1;
      end
    end
  end

  // State register; reset abandons any outstanding dcache wait.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state <= RUN;
    end else begin
      r_state <= w_next;
    end
  end

  // A completed dcache access must always move EX_MEM on, otherwise the
  // same request would be reissued in the following cycle.
  a_dhit_advances : assert property (@(posedge CLK) disable iff (!nRST)
    (dhit && !memwb_halt && (r_state != HALT) && (w_mem || (r_state == DWAIT)))
      |-> exmem_en);

`ifdef PIPE_CTRL_PERF_EN
  // Saturating performance counters, frozen once the core has halted.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
      dwait_cnt <= '0;
    end else if (r_state != HALT) begin
      if (!pc_en && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end
      if (pc_redirect && (flush_cnt != '1)) begin
        flush_cnt <= flush_cnt + CNT_W'(1);
      end
      if ((r_state == DWAIT) && (dwait_cnt != '1)) begin
        dwait_cnt <= dwait_cnt + CNT_W'(1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Testbench for pipeline_ctrl: directed vector table for single-cycle
// decisions in RUN, plus hand-written sequences for DWAIT, REDIR, HALT and
// asynchronous reset. Counter checks are compiled in with PIPE_CTRL_PERF_EN.
module tb_pipeline_ctrl;

  logic       CLK = 1'b0;
  logic       nRST;
  logic       ihit, dhit, exmem_dREN, exmem_dWEN, redirect, idex_dREN, memwb_halt;
  logic [4:0] idex_rd, ifid_rs1, ifid_rs2;
  logic       pc_en, pc_redirect, ifid_en, idex_en, exmem_en, memwb_en;
  logic       ifid_flush, idex_flush, exmem_flush, memwb_flush;
  logic       memwb_dhit, dREN_o, dWEN_o, halted;
  logic [1:0] state_o;
`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] stall_cnt, flush_cnt, dwait_cnt;
`endif

  int checks = 0;
  int failures = 0;

  // Bit order: pc_en, pc_redirect, en{ifid,idex,exmem,memwb},
  // flush{ifid,idex,exmem,memwb}, memwb_dhit, dREN_o, dWEN_o, halted, state_o
  logic [15:0] outs;
  assign outs = {pc_en, pc_redirect, ifid_en, idex_en, exmem_en, memwb_en,
                 ifid_flush, idex_flush, exmem_flush, memwb_flush,
                 memwb_dhit, dREN_o, dWEN_o, halted, state_o};

  pipeline_ctrl dut (
    .CLK         (CLK),
    .nRST        (nRST),
    .ihit        (ihit),
    .dhit        (dhit),
    .exmem_dREN  (exmem_dREN),
    .exmem_dWEN  (exmem_dWEN),
    .redirect    (redirect),
    .idex_dREN   (idex_dREN),
    .idex_rd     (idex_rd),
    .ifid_rs1    (ifid_rs1),
    .ifid_rs2    (ifid_rs2),
    .memwb_halt  (memwb_halt),
    .pc_en       (pc_en),
    .pc_redirect (pc_redirect),
    .ifid_en     (ifid_en),
    .idex_en     (idex_en),
    .exmem_en    (exmem_en),
    .memwb_en    (memwb_en),
    .ifid_flush  (ifid_flush),
    .idex_flush  (idex_flush),
    .exmem_flush (exmem_flush),
    .memwb_flush (memwb_flush),
    .memwb_dhit  (memwb_dhit),
    .dREN_o      (dREN_o),
    .dWEN_o      (dWEN_o),
    .halted      (halted),
    .state_o     (state_o)
`ifdef PIPE_CTRL_PERF_EN
    ,
    .stall_cnt   (stall_cnt),
    .flush_cnt   (flush_cnt),
    .dwait_cnt   (dwait_cnt)
`endif
  );

  always #5 CLK = ~CLK;

  typedef struct {
    string       name;
    logic        ihit;
    logic        dhit;
    logic        dren;
    logic        dwen;
    logic        redir;
    logic        idex_dren;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs[10];

  function automatic logic [15:0] ex(input logic pe, input logic pr,
                                     input logic [3:0] en, input logic [3:0] fl,
                                     input logic md, input logic dr, input logic dw,
                                     input logic hl, input logic [1:0] st);
    return {pe, pr, en, fl, md, dr, dw, hl, st};
  endfunction

  task automatic applyStimulus(input logic i_ihit, input logic i_dhit,
                               input logic i_dren, input logic i_dwen,
                               input logic i_redir, input logic i_idex_dren,
                               input logic [4:0] i_rd, input logic [4:0] i_rs1,
                               input logic [4:0] i_rs2, input logic i_halt);
    ihit       = i_ihit;
    dhit       = i_dhit;
    exmem_dREN = i_dren;
    exmem_dWEN = i_dwen;
    redirect   = i_redir;
    idex_dREN  = i_idex_dren;
    idex_rd    = i_rd;
    ifid_rs1   = i_rs1;
    ifid_rs2   = i_rs2;
    memwb_halt = i_halt;
  endtask

  task automatic applyIdle();
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
  endtask

  task automatic checkOutput(input string name, input logic [15:0] exp);
    checks++;
    if (outs !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %b required %b", name, outs, exp);
    end
  endtask

  task automatic checkCount(input string name, input logic [31:0] act,
                            input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  localparam logic [15:0] E_IDLE  = 16'b1_0_1111_0000_0_0_0_0_00;
  localparam logic [15:0] E_LU    = 16'b0_0_0111_0100_0_0_0_0_00;
  localparam logic [15:0] E_REDIR = 16'b1_1_1111_1110_0_0_0_0_00;
  localparam logic [15:0] E_RSQ   = 16'b1_0_1111_1000_0_0_0_0_10;
  localparam logic [15:0] E_HALT  = 16'b0_0_0000_0000_0_0_0_1_11;

  initial begin
    vecs[0] = '{"idle",        1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, E_IDLE};
    vecs[1] = '{"lu_rs2",      1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd5, 5'd3, 5'd5, E_LU};
    vecs[2] = '{"lu_rd0",      1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 5'd0, 5'd0, E_IDLE};
    vecs[3] = '{"lu_rs1",      1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd7, 5'd7, 5'd2, E_LU};
    vecs[4] = '{"no_load",     1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd5, 5'd3, 5'd5, E_IDLE};
    vecs[5] = '{"imiss",       1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0,
                ex(1'b0, 1'b0, 4'b1111, 4'b1000, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0)};
    vecs[6] = '{"lu_imiss",    1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd5, 5'd1, 5'd5, E_LU};
    vecs[7] = '{"store_hit",   1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0,
                ex(1'b1, 1'b0, 4'b1111, 4'b0000, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0)};
    vecs[8] = '{"load_hit_lu", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 5'd9, 5'd9, 5'd4,
                ex(1'b0, 1'b0, 4'b0111, 4'b0100, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0)};
    vecs[9] = '{"dhit_nomem",  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, E_IDLE};

    // Reset state, checked while reset is asserted and after release.
    nRST = 1'b0;
    applyIdle();
    #2;
    checkOutput("reset_state", E_IDLE);
    step();
    nRST = 1'b1;
    @(negedge CLK);
    checkOutput("post_reset_idle", E_IDLE);
    step();

    // Load miss for three cycles, then completion.
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      @(negedge CLK);
      checkOutput($sformatf("dwait_stall%0d", k),
                  ex(1'b0, 1'b0, 4'b0001, 4'b0001, 1'b0, 1'b1, 1'b0, 1'b0,
                     (k == 0) ? 2'd0 : 2'd1));
      step();
    end
    dhit = 1'b1;
    @(negedge CLK);
    checkOutput("dwait_dhit", ex(1'b1, 1'b0, 4'b1111, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b0, 2'd1));
    step();
    applyIdle();
    @(negedge CLK);
    checkOutput("dwait_exit", E_IDLE);
`ifdef PIPE_CTRL_PERF_EN
    checkCount("dwait_cnt_a", dwait_cnt, 32'd3);
    checkCount("stall_cnt_a", stall_cnt, 32'd3);
`endif
    step();

    // Single-cycle decisions from RUN.
    for (int i = 0; i < 10; i++) begin
      applyStimulus(vecs[i].ihit, vecs[i].dhit, vecs[i].dren, vecs[i].dwen,
                    vecs[i].redir, vecs[i].idex_dren, vecs[i].rd, vecs[i].rs1,
                    vecs[i].rs2, 1'b0);
      @(negedge CLK);
      checkOutput(vecs[i].name, vecs[i].exp);
      step();
    end

    // Redirect, then the REDIR squash cycle, then back to RUN.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    @(negedge CLK);
    checkOutput("redirect", E_REDIR);
    step();
    applyIdle();
    @(negedge CLK);
    checkOutput("redir_squash", E_RSQ);
    step();
    @(negedge CLK);
    checkOutput("redir_exit", E_IDLE);
    step();

    // Redirect beats a simultaneous load-use hazard.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd5, 5'd5, 5'd0, 1'b0);
    @(negedge CLK);
    checkOutput("redirect_over_lu", E_REDIR);
    step();
    applyIdle();
    @(negedge CLK);
    checkOutput("redir_lu_squash", E_RSQ);
    step();

    // Redirect arriving during DWAIT is held until dhit.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    @(negedge CLK);
    checkOutput("dw_redir_stall0", ex(1'b0, 1'b0, 4'b0001, 4'b0001, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0));
    step();
    redirect = 1'b1;
    @(negedge CLK);
    checkOutput("dw_redir_held", ex(1'b0, 1'b0, 4'b0001, 4'b0001, 1'b0, 1'b0, 1'b1, 1'b0, 2'd1));
    step();
    dhit = 1'b1;
    @(negedge CLK);
    checkOutput("dw_redir_apply", ex(1'b1, 1'b1, 4'b1111, 4'b1110, 1'b1, 1'b0, 1'b1, 1'b0, 2'd1));
    step();
    applyIdle();
    @(negedge CLK);
    checkOutput("dw_redir_squash", E_RSQ);
    step();
    @(negedge CLK);
    checkOutput("dw_redir_exit", E_IDLE);
`ifdef PIPE_CTRL_PERF_EN
    checkCount("flush_cnt_b", flush_cnt, 32'd3);
    checkCount("stall_cnt_b", stall_cnt, 32'd10);
    checkCount("dwait_cnt_b", dwait_cnt, 32'd5);
`endif
    step();

    // Halt wins over a pending store miss and is sticky.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1);
    @(negedge CLK);
    checkOutput("halt_entry", ex(1'b0, 1'b0, 4'b0001, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0));
    step();
    @(negedge CLK);
    checkOutput("halt_state", E_HALT);
    step();
    memwb_halt = 1'b0;
    @(negedge CLK);
    checkOutput("halt_sticky1", E_HALT);
    step();
    @(negedge CLK);
    checkOutput("halt_sticky2", E_HALT);
`ifdef PIPE_CTRL_PERF_EN
    checkCount("stall_cnt_frozen", stall_cnt, 32'd11);
`endif
    step();

    // Asynchronous reset mid-HALT, away from any clock edge.
    applyIdle();
    #2;
    nRST = 1'b0;
    #1;
    checkOutput("async_reset", E_IDLE);
`ifdef PIPE_CTRL_PERF_EN
    checkCount("stall_cnt_reset", stall_cnt, 32'd0);
`endif
    #1;
    nRST = 1'b1;
    step();
    @(negedge CLK);
    checkOutput("after_reset_run", E_IDLE);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
